// File: rtl/alarm_ring_ctrl.sv
// Alarm-sounding controller: detects the alarm minute, then sequences ring,
// snooze and auto-off periods from the one_second timebase.
module alarm_ring_ctrl #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        one_second,
    input  logic        alarm_enable,
    input  logic        snooze_button,
    input  logic        stop_button,
    input  logic [15:0] current_time,
    input  logic [15:0] alarm_time,
    output logic        sound_alarm,
    output logic        snooze_led,
    output logic [1:0]  alarm_state,
    output logic [2:0]  snooze_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZE  = 2'b10
    } state_t;

    localparam logic [9:0] RING_LAST   = 10'(RING_SECONDS - 1);
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECONDS - 1);
    localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

    state_t     state;
    state_t     state_nxt;
    logic [9:0] sec_cnt;
    logic [9:0] sec_nxt;
    logic [2:0] count_nxt;
    logic       match;
    logic       match_d;
    logic       snooze_d;
    logic       stop_d;
    logic       trigger;
    logic       snooze_press;
    logic       stop_press;

    assign match        = alarm_enable && (current_time == alarm_time);
    assign trigger      = match && !match_d;
    assign snooze_press = snooze_button && !snooze_d;
    assign stop_press   = stop_button && !stop_d;

    // Any button press in a cycle suppresses counting of a coincident second.
    always_comb begin
        state_nxt = state;
        sec_nxt   = sec_cnt;
        count_nxt = snooze_count;
        case (state)
            IDLE: begin
                if (trigger) state_nxt = RINGING;
            end
            RINGING: begin
                if (stop_press) begin
                    state_nxt = IDLE;
                end else if (snooze_press) begin
                    if (snooze_count < SNOOZE_MAX) begin
                        state_nxt = SNOOZE;
                        count_nxt = snooze_count + 3'd1;
                    end
                end else if (one_second) begin
                    if (sec_cnt == RING_LAST) state_nxt = IDLE;
                    else                      sec_nxt   = sec_cnt + 10'd1;
                end
            end
            SNOOZE: begin
                if (stop_press) begin
                    state_nxt = IDLE;
                end else if (!snooze_press && one_second) begin
                    if (sec_cnt == SNOOZE_LAST) state_nxt = RINGING;
                    else                        sec_nxt   = sec_cnt + 10'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!alarm_enable)      state_nxt = IDLE;
        if (state_nxt == IDLE)  count_nxt = 3'd0;
        if (state_nxt != state) sec_nxt   = 10'd0;
    end

    // match_d and button history reset high so levels already present at
    // reset release are not mistaken for fresh events.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            sec_cnt      <= 10'd0;
            snooze_count <= 3'd0;
            sound_alarm  <= 1'b0;
            snooze_led   <= 1'b0;
            alarm_state  <= 2'b00;
            match_d      <= 1'b1;
            snooze_d     <= 1'b1;
            stop_d       <= 1'b1;
        end else begin
            state        <= state_nxt;
            sec_cnt      <= sec_nxt;
            snooze_count <= count_nxt;
            sound_alarm  <= (state_nxt == RINGING);
            snooze_led   <= (state_nxt == SNOOZE);
            alarm_state  <= state_nxt;
            match_d      <= match;
            snooze_d     <= snooze_button;
            stop_d       <= stop_button;
        end
    end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl: directed scenarios plus random stimulus, all
// checked every cycle against an elapsed-seconds behavioural model.
module tb_alarm_ring_ctrl;

    localparam int RS = 4;
    localparam int SS = 3;
    localparam int MS = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        one_second = 1'b0;
    logic        alarm_enable = 1'b0;
    logic        snooze_button = 1'b0;
    logic        stop_button = 1'b0;
    logic [15:0] current_time = 16'h0000;
    logic [15:0] alarm_time = 16'h0730;
    logic        sound_alarm;
    logic        snooze_led;
    logic [1:0]  alarm_state;
    logic [2:0]  snooze_count;

    alarm_ring_ctrl #(
        .RING_SECONDS(RS), .SNOOZE_SECONDS(SS), .MAX_SNOOZE(MS)
    ) dut (
        .clock(clock), .reset(reset), .one_second(one_second),
        .alarm_enable(alarm_enable), .snooze_button(snooze_button),
        .stop_button(stop_button), .current_time(current_time),
        .alarm_time(alarm_time), .sound_alarm(sound_alarm),
        .snooze_led(snooze_led), .alarm_state(alarm_state),
        .snooze_count(snooze_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: mode 0 idle, 1 ringing, 2 snoozing; secs counts seconds elapsed
    // in the current period, used counts snoozes taken in this alarm event.
    int m_mode, m_secs, m_used;
    bit m_prev_match, m_prev_snz, m_prev_stop;

    always @(posedge clock or negedge reset) begin
        bit now_match, trig, snz, stp;
        if (!reset) begin
            m_mode = 0; m_secs = 0; m_used = 0;
            m_prev_match = 1; m_prev_snz = 1; m_prev_stop = 1;
        end else begin
            now_match = alarm_enable && (current_time == alarm_time);
            trig = now_match && !m_prev_match;
            snz  = snooze_button && !m_prev_snz;
            stp  = stop_button && !m_prev_stop;
            if (!alarm_enable) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (trig) begin m_mode = 1; m_secs = 0; end
            end else if (stp) begin
                m_mode = 0;
            end else if (snz) begin
                if (m_mode == 1 && m_used < MS) begin
                    m_used++; m_mode = 2; m_secs = 0;
                end
            end else if (one_second) begin
                m_secs++;
                if (m_mode == 1 && m_secs == RS) m_mode = 0;
                else if (m_mode == 2 && m_secs == SS) begin m_mode = 1; m_secs = 0; end
            end
            if (m_mode == 0) begin m_used = 0; m_secs = 0; end
            m_prev_match = now_match;
            m_prev_snz = snooze_button;
            m_prev_stop = stop_button;
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clock) begin
        if (cmp_en) begin
            check("sound_alarm", 16'(sound_alarm), 16'(m_mode == 1));
            check("snooze_led", 16'(snooze_led), 16'(m_mode == 2));
            check("alarm_state", 16'(alarm_state), 16'(m_mode));
            check("snooze_count", 16'(snooze_count), 16'(m_used));
        end
    end

    task automatic cyc(input bit os);
        one_second = os;
        @(posedge clock);
        #2;
        one_second = 1'b0;
    endtask

    task automatic ring_again();
        current_time = 16'h0731; cyc(0);
        current_time = 16'h0730; cyc(0);
    endtask

    initial begin
        alarm_enable = 1'b1;
        current_time = 16'h0729;
        #12;
        check("rst_sound", 16'(sound_alarm), 16'd0);
        check("rst_state", 16'(alarm_state), 16'd0);
        check("rst_count", 16'(snooze_count), 16'd0);
        @(negedge clock); reset = 1'b1;
        cmp_en = 1'b1;
        cyc(0); cyc(0);

        // First matching edge starts ringing; RS pulses later auto-off.
        current_time = 16'h0730; cyc(0);
        check("ring_on", 16'(alarm_state), 16'd1);
        check("ring_sound", 16'(sound_alarm), 16'd1);
        for (int i = 0; i < RS - 1; i++) cyc(1);
        check("ring_before_off", 16'(alarm_state), 16'd1);
        cyc(1);
        check("auto_off", 16'(alarm_state), 16'd0);

        // Snooze twice, third snooze ignored.
        ring_again();
        snooze_button = 1'b1; cyc(0); snooze_button = 1'b0;
        check("snooze1_state", 16'(alarm_state), 16'd2);
        check("snooze1_count", 16'(snooze_count), 16'd1);
        check("snooze1_sound", 16'(sound_alarm), 16'd0);
        cyc(1); cyc(1);
        check("snooze_hold", 16'(alarm_state), 16'd2);
        cyc(1);
        check("rering", 16'(alarm_state), 16'd1);
        snooze_button = 1'b1; cyc(0); snooze_button = 1'b0;
        check("snooze2_count", 16'(snooze_count), 16'd2);
        cyc(1); cyc(1); cyc(1);
        snooze_button = 1'b1; cyc(0); snooze_button = 1'b0;
        check("snooze3_ignored", 16'(alarm_state), 16'd1);
        cyc(0);

        // Stop and snooze together: stop wins; no re-ring this minute.
        stop_button = 1'b1; snooze_button = 1'b1; cyc(1);
        stop_button = 1'b0; snooze_button = 1'b0;
        check("stop_state", 16'(alarm_state), 16'd0);
        check("stop_count", 16'(snooze_count), 16'd0);
        for (int i = 0; i < 20; i++) cyc(0);
        check("no_rering", 16'(alarm_state), 16'd0);

        // Disable during snooze, re-enable inside the same minute.
        ring_again();
        snooze_button = 1'b1; cyc(0); snooze_button = 1'b0;
        alarm_enable = 1'b0; cyc(0);
        check("disable_idle", 16'(alarm_state), 16'd0);
        alarm_enable = 1'b1; cyc(0);
        check("reenable_ring", 16'(alarm_state), 16'd1);

        // Asynchronous reset mid-ring.
        @(negedge clock); #1 reset = 1'b0;
        #1 check("async_reset_sound", 16'(sound_alarm), 16'd0);
        @(negedge clock); #1 reset = 1'b1;
        cyc(0); cyc(0); cyc(0);
        check("post_reset_idle", 16'(alarm_state), 16'd0);

        // Held snooze across ring entry is not a press.
        current_time = 16'h0731; cyc(0);
        snooze_button = 1'b1; cyc(0);
        current_time = 16'h0730; cyc(0);
        cyc(0); cyc(0);
        check("held_snooze_ignored", 16'(alarm_state), 16'd1);
        snooze_button = 1'b0; cyc(0);
        snooze_button = 1'b1; cyc(0);
        check("repress_snooze", 16'(alarm_state), 16'd2);
        snooze_button = 1'b0;

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] times [3];
            times[0] = 16'h0729; times[1] = 16'h0730; times[2] = 16'h0731;
            alarm_enable = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 15) == 0) current_time = times[$urandom_range(0, 2)];
            if ($urandom_range(0, 5) == 0) snooze_button = ~snooze_button;
            stop_button = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 499) == 0) begin
                @(negedge clock); #1 reset = 1'b0;
                #2 reset = 1'b1;
            end
            cyc($urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_ring_ctrl.md
# alarm_ring_ctrl

Alarm-sounding controller for the alarm clock. It watches the running clock time against the stored alarm time and decides when the alarm sounds. It sequences the ring, snooze and auto-off periods from the `one_second` timebase, and drives the buzzer and snooze indicator. It sits beside `fsm`, consuming the same `one_second` pulse and the current/alarm time registers held in the datapath.

## Interface
- `RING_SECONDS`, default 60: number of `one_second` pulses the alarm rings before auto-off; range 1..1023.
- `SNOOZE_SECONDS`, default 300: number of `one_second` pulses spent in snooze before re-ringing; range 1..1023.
- `MAX_SNOOZE`, default 3: snoozes allowed per alarm event; range 0..7.

Ports:
- `clock` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset; forces all state to reset values immediately.
- `one_second` in 1: single-cycle pulse, once per second.
- `alarm_enable` in 1: level; alarm function armed when high.
- `snooze_button` in 1: level, already synchronised upstream.
- `stop_button` in 1: level, already synchronised upstream.
- `current_time` in 16: running time, BCD HH:MM, bits [15:12] hour tens down to [3:0] minute units.
- `alarm_time` in 16: stored alarm time, same format.
- `sound_alarm` out 1: buzzer enable.
- `snooze_led` out 1: high while in SNOOZE.
- `alarm_state` out 2: 00 IDLE, 01 RINGING, 10 SNOOZE; 11 is never driven.
- `snooze_count` out 3: snoozes used in the current alarm event.

## Operation
- `match` = `alarm_enable` & (`current_time` == `alarm_time`), combinational 16-bit equality with no BCD validity check.
- `match_d` registers `match` every cycle.
- `trigger` = `match` & ~`match_d`, so the alarm fires only on the first cycle of a matching minute.
- Button presses are rising edges: `press` = button & ~button_d, with button_d registered. Holding a button counts as one press.
- Internal `sec_cnt` is 10 bits. It increments on `one_second` in RINGING or SNOOZE and clears to 0 on every state transition.
- IDLE:
  - `trigger` → RINGING.
  - `snooze_count` is held at 0 in IDLE.
- RINGING (`sound_alarm`=1):
  - stop press → IDLE.
  - Otherwise, snooze press with `snooze_count` < `MAX_SNOOZE` → SNOOZE, `snooze_count`+1.
  - Snooze press with `snooze_count` == `MAX_SNOOZE` is ignored; ringing continues.
  - Otherwise, `one_second` with `sec_cnt` == `RING_SECONDS`-1 → IDLE (auto-off).
- SNOOZE (`snooze_led`=1, `sound_alarm`=0):
  - stop press → IDLE.
  - Snooze press is ignored.
  - `one_second` with `sec_cnt` == `SNOOZE_SECONDS`-1 → RINGING.
- Any state: `alarm_enable` low → IDLE on the next edge. This has the highest priority.
- Priority within a cycle: `alarm_enable` low > stop > snooze > timer expiry.
- `trigger` is ignored in RINGING and SNOOZE.

## Timing
- Reset values:
  - state IDLE; `sound_alarm`, `snooze_led` = 0; `alarm_state` = 00; `snooze_count` = 0; `sec_cnt` = 0.
  - `match_d` = 1, so an already-matching minute does not ring after reset.
  - button_d = 1, so a held button is not a press.
- All outputs are decoded from registered state (Moore) and change only after a rising edge or on reset assertion.
- Latency:
  - `current_time` becomes equal to `alarm_time` before edge N → `sound_alarm` high after edge N.
  - Button rising before edge N → state change after edge N.
- RINGING lasts exactly `RING_SECONDS` `one_second` pulses when there is no button activity.
- A `one_second` pulse coinciding with a stop or snooze press is not counted.
- Reset asserted mid-ring drops `sound_alarm` asynchronously. After release, no re-ring occurs within the same matching minute.
- `alarm_enable` toggled low→high within a matching minute re-triggers, because `match` rises again.

## Test plan
- Reset, `alarm_time`=16'h0730, `alarm_enable`=1; step `current_time` 0729→0730 → `sound_alarm`=1 and `alarm_state`=01 one edge later. It stays high for a 60-pulse minute with `RING_SECONDS`=4? No: with `RING_SECONDS`=4, it drops to IDLE after the 4th `one_second` pulse.
- With `RING_SECONDS`=4, `SNOOZE_SECONDS`=3, `MAX_SNOOZE`=2: ring, press snooze → SNOOZE, `snooze_count`=1, `sound_alarm`=0. After the 3rd pulse → RINGING. Snooze again → `snooze_count`=2. Third snooze is ignored and ringing continues.
- While RINGING, assert stop and snooze in the same cycle → IDLE, `snooze_count`=0. Hold `current_time`=0730 for 20 more cycles → no re-ring.
- While SNOOZE, drive `alarm_enable`=0 → IDLE next edge. Re-enable while `current_time` is still 0730 → RINGING next edge.
- Assert `reset` low mid-RINGING → `sound_alarm`=0 immediately. Release with `current_time`=`alarm_time` → remains IDLE.
- Hold `snooze_button` high across entry to RINGING → no snooze taken until the button is released and pressed again.
